// File: rtl/qam_pkg.sv
// Shared types and constants for the 16-QAM symbol sequencer.
package qam_pkg;

  localparam int BITS_PER_SYM = 4;
  localparam int NBITS_W      = $clog2(BITS_PER_SYM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // 3-bit two's complement amplitude levels
  localparam logic signed [2:0] LVL_M3 = 3'sb101;
  localparam logic signed [2:0] LVL_M1 = 3'sb111;
  localparam logic signed [2:0] LVL_P1 = 3'sb001;
  localparam logic signed [2:0] LVL_P3 = 3'sb011;

  // Gray-coded bit pair to amplitude level
  function automatic logic signed [2:0] gray_to_level(input logic [1:0] g);
    case (g)
      2'b00:   return LVL_M3;
      2'b01:   return LVL_M1;
      2'b11:   return LVL_P1;
      default: return LVL_P3;
    endcase
  endfunction

endpackage

// File: rtl/qam_bit_deserializer.sv
// Mid-bit sampler, 4-bit shift register and single-entry symbol staging buffer.
module qam_bit_deserializer
  import qam_pkg::*;
#(
  parameter int BIT_PERIOD = 50
) (
  input  logic                    inp_clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    inputsignal,
  input  logic                    apply,
  output logic [BITS_PER_SYM-1:0] stage_bits,
  output logic                    stage_full,
  output logic                    overrun
);

  localparam int CNT_W = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CNT_W-1:0]   MID      = CNT_W'(BIT_PERIOD / 2);
  localparam logic [CNT_W-1:0]   LAST     = CNT_W'(BIT_PERIOD - 1);
  localparam logic [NBITS_W-1:0] NB_LAST  = NBITS_W'(BITS_PER_SYM - 1);

  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_SYM-1:0] shift_q, shift_d;
  logic [NBITS_W-1:0]      nbits_q, nbits_d;
  logic                    load_q, load_d;
  logic [BITS_PER_SYM-1:0] stage_q, stage_d;
  logic                    stage_full_q, stage_full_d;
  logic                    overrun_q, overrun_d;
  logic                    sample;

  // Bit timing, shifting, and staging with overwrite detection
  always_comb begin
    sample       = en && (bit_cnt_q == MID);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    nbits_d      = nbits_q;
    load_d       = 1'b0;
    stage_d      = stage_q;
    stage_full_d = stage_full_q;
    overrun_d    = overrun_q;
    if (en) begin
      bit_cnt_d = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + 1'b1;
    end
    if (sample) begin
      shift_d = {shift_q[BITS_PER_SYM-2:0], inputsignal};
      nbits_d = (nbits_q == NB_LAST) ? '0 : nbits_q + 1'b1;
      load_d  = (nbits_q == NB_LAST);
    end
    if (apply) begin
      stage_full_d = 1'b0;
    end
    // A load in the same cycle as an apply refills the buffer; apply reads the old value
    if (load_q) begin
      stage_d      = shift_q;
      stage_full_d = 1'b1;
      if (stage_full_q && !apply) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Deserializer state registers
  always_ff @(posedge inp_clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      nbits_q      <= '0;
      load_q       <= 1'b0;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      nbits_q      <= nbits_d;
      load_q       <= load_d;
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      overrun_q    <= overrun_d;
    end
  end

  assign stage_bits = stage_q;
  assign stage_full = stage_full_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/qam_symbol_sequencer.sv
// 16-QAM controller: symbol application and sine/cosine generator sequencing.
module qam_symbol_sequencer
  import qam_pkg::*;
#(
  parameter int BIT_PERIOD = 50,
  parameter int ITERS      = 12,
  parameter int PHASE_W    = 8,
  parameter int PHASE_INC  = 1
) (
  input  logic                  inp_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  inputsignal,
  output logic signed [2:0]     sym_i,
  output logic signed [2:0]     sym_q,
  output logic                  sym_valid,
  output logic [PHASE_W-1:0]    phase,
  output logic                  initialize,
  output logic [3:0]            iter,
  output logic                  sample_strobe,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [3:0]         ITER_LAST = 4'(ITERS - 1);
  localparam logic [PHASE_W-1:0] PH_INC    = PHASE_W'(PHASE_INC);

  seq_state_e              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    apply;
  logic [BITS_PER_SYM-1:0] stage_bits;
  logic                    stage_full;

  logic signed [2:0]       sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic                    sym_valid_q, sym_valid_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic                    initialize_q, initialize_d;
  logic [3:0]              iter_q, iter_d;
  logic                    sample_strobe_q, sample_strobe_d;

  qam_bit_deserializer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_deser (
    .inp_clk    (inp_clk),
    .rst        (rst),
    .en         (en),
    .inputsignal(inputsignal),
    .apply      (apply),
    .stage_bits (stage_bits),
    .stage_full (stage_full),
    .overrun    (overrun)
  );

  // FSM state and iteration counter
  always_ff @(posedge inp_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: one sample is INIT, ITERS iterations, then DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (stage_full && en) state_d = ST_INIT;
      ST_INIT: state_d = ST_ITER;
      ST_ITER: if (cnt_q == ITER_LAST) state_d = ST_DONE;
      ST_DONE: state_d = en ? ST_INIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state, registered one cycle later
  always_comb begin
    apply           = stage_full && (((state_q == ST_IDLE) && en) || (state_q == ST_DONE));
    cnt_d           = cnt_q;
    if (state_q == ST_INIT) cnt_d = '0;
    else if (state_q == ST_ITER) cnt_d = cnt_q + 1'b1;
    sym_i_d         = apply ? gray_to_level(stage_bits[3:2]) : sym_i_q;
    sym_q_d         = apply ? gray_to_level(stage_bits[1:0]) : sym_q_q;
    sym_valid_d     = apply;
    initialize_d    = (state_q == ST_INIT);
    iter_d          = (state_q == ST_ITER) ? cnt_q : 4'd0;
    sample_strobe_d = (state_q == ST_DONE);
    // Phase advances after its strobe so the strobe presents the phase just computed
    phase_d         = sample_strobe_q ? phase_q + PH_INC : phase_q;
  end

  // Output registers
  always_ff @(posedge inp_clk) begin
    if (rst) begin
      sym_i_q         <= '0;
      sym_q_q         <= '0;
      sym_valid_q     <= 1'b0;
      phase_q         <= '0;
      initialize_q    <= 1'b0;
      iter_q          <= '0;
      sample_strobe_q <= 1'b0;
    end else begin
      sym_i_q         <= sym_i_d;
      sym_q_q         <= sym_q_d;
      sym_valid_q     <= sym_valid_d;
      phase_q         <= phase_d;
      initialize_q    <= initialize_d;
      iter_q          <= iter_d;
      sample_strobe_q <= sample_strobe_d;
    end
  end

  assign sym_i         = sym_i_q;
  assign sym_q         = sym_q_q;
  assign sym_valid     = sym_valid_q;
  assign phase         = phase_q;
  assign initialize    = initialize_q;
  assign iter          = iter_q;
  assign sample_strobe = sample_strobe_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qam_symbol_sequencer.sv
// Testbench for qam_symbol_sequencer: main instance (BIT_PERIOD=50, ITERS=12)
// with a symbol scoreboard, plus a fast instance (BIT_PERIOD=2, ITERS=16) for overrun.
module tb_qam_symbol_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_m, en_m, in_m;
  logic signed [2:0] sym_i_m, sym_q_m;
  logic              sym_valid_m, initialize_m, sample_strobe_m, busy_m, overrun_m;
  logic [7:0]        phase_m;
  logic [3:0]        iter_m;

  logic              rst_o, en_o, in_o;
  logic signed [2:0] sym_i_o, sym_q_o;
  logic              sym_valid_o, initialize_o, sample_strobe_o, busy_o, overrun_o;
  logic [7:0]        phase_o;
  logic [3:0]        iter_o;

  qam_symbol_sequencer #(.BIT_PERIOD(50), .ITERS(12), .PHASE_W(8), .PHASE_INC(1)) dut_m (
    .inp_clk(clk), .rst(rst_m), .en(en_m), .inputsignal(in_m),
    .sym_i(sym_i_m), .sym_q(sym_q_m), .sym_valid(sym_valid_m), .phase(phase_m),
    .initialize(initialize_m), .iter(iter_m), .sample_strobe(sample_strobe_m),
    .busy(busy_m), .overrun(overrun_m)
  );

  qam_symbol_sequencer #(.BIT_PERIOD(2), .ITERS(16), .PHASE_W(8), .PHASE_INC(1)) dut_o (
    .inp_clk(clk), .rst(rst_o), .en(en_o), .inputsignal(in_o),
    .sym_i(sym_i_o), .sym_q(sym_q_o), .sym_valid(sym_valid_o), .phase(phase_o),
    .initialize(initialize_o), .iter(iter_o), .sample_strobe(sample_strobe_o),
    .busy(busy_o), .overrun(overrun_o)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         abs_cyc  = 0;
  int         strb_cnt = 0;
  int         last_strb = -1;
  bit         wrap_seen = 1'b0;
  bit         prev_busy = 1'b0;
  logic [5:0] sb_q[$];
  logic [5:0] last_exp;

  always @(posedge clk) abs_cyc <= abs_cyc + 1;

  // Reference Gray table: 00->-3, 01->-1, 11->+1, 10->+3
  function automatic logic [2:0] lvl(input logic [1:0] g);
    case (g)
      2'b00:   lvl = 3'b101;
      2'b01:   lvl = 3'b111;
      2'b11:   lvl = 3'b001;
      default: lvl = 3'b011;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scoreboard and strobe monitor for the main instance
  always @(negedge clk) begin
    logic [5:0] exp;
    if (rst_m) begin
      strb_cnt  = 0;
      last_strb = -1;
      prev_busy = 1'b0;
    end else begin
      if (sym_valid_m) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: sym_valid with got I/Q=%b, nothing expected", {sym_i_m, sym_q_m});
        end else begin
          exp = sb_q.pop_front();
          if ({sym_i_m, sym_q_m} !== exp) begin
            n_fail++;
            $display("FAIL sb_symbol: got I/Q=%b expected %b", {sym_i_m, sym_q_m}, exp);
          end
        end
        n_checks++;
        if (!sample_strobe_m && prev_busy) begin
          n_fail++;
          $display("FAIL sym_on_done: sym_valid got strobe=%b expected 1 (mid-sample change)", sample_strobe_m);
        end
      end
      if (sample_strobe_m) begin
        n_checks++;
        if (phase_m !== 8'(strb_cnt)) begin
          n_fail++;
          $display("FAIL strobe_phase: got %0d expected %0d", phase_m, 8'(strb_cnt));
        end
        if (last_strb >= 0) begin
          n_checks++;
          if (abs_cyc - last_strb != 14) begin
            n_fail++;
            $display("FAIL strobe_spacing: got %0d expected 14", abs_cyc - last_strb);
          end
        end
        if (strb_cnt == 256 && phase_m == 8'd0) wrap_seen = 1'b1;
        last_strb = abs_cyc;
        strb_cnt++;
      end
      prev_busy = busy_m;
    end
  end

  task automatic release_main();
    rst_m = 1'b1; en_m = 1'b0; in_m = 1'b0;
    step(); step();
    rst_m = 1'b0; en_m = 1'b1;
    cyc = -1;
  endtask

  task automatic drive_symbol(input logic [3:0] s);
    last_exp = {lvl(s[3:2]), lvl(s[1:0])};
    sb_q.push_back(last_exp);
    for (int n = 0; n < 200; n++) begin
      in_m = s[3 - n / 50];
      step();
    end
  endtask

  task automatic test_reset();
    rst_m = 1'b1; en_m = 1'b0; in_m = 1'b0;
    rst_o = 1'b1; en_o = 1'b0; in_o = 1'b0;
    step(); step();
    n_checks++;
    if ({sym_i_m, sym_q_m, sym_valid_m, phase_m, initialize_m, iter_m, sample_strobe_m, busy_m, overrun_m} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_main: got %h expected 0", {sym_i_m, sym_q_m, sym_valid_m, phase_m, initialize_m, iter_m, sample_strobe_m, busy_m, overrun_m});
    end
    n_checks++;
    if ({sym_i_o, sym_q_o, sym_valid_o, phase_o, initialize_o, iter_o, sample_strobe_o, busy_o, overrun_o} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_fast: got %h expected 0", {sym_i_o, sym_q_o, sym_valid_o, phase_o, initialize_o, iter_o, sample_strobe_o, busy_o, overrun_o});
    end
  endtask

  task automatic test_overrun();
    logic [3:0] s;
    rst_o = 1'b0; en_o = 1'b1;
    cyc = -1;
    for (int n = 0; n < 60; n++) begin
      case (n / 8)
        0:       s = 4'b0001;
        1:       s = 4'b0010;
        2:       s = 4'b1100;
        default: s = 4'b1111;
      endcase
      in_o = s[3 - (n % 8) / 2];
      step();
      if (cyc == 9) begin
        n_checks++;
        if ({sym_valid_o, sym_i_o, sym_q_o} !== 7'b1_101_111) begin
          n_fail++;
          $display("FAIL ovr_first_sym: got %b expected 1_101_111", {sym_valid_o, sym_i_o, sym_q_o});
        end
      end
      if (cyc == 20) begin
        n_checks++;
        if (overrun_o !== 1'b0) begin
          n_fail++;
          $display("FAIL ovr_not_yet: got %b expected 0", overrun_o);
        end
      end
      if (cyc == 24) begin
        n_checks++;
        if (overrun_o !== 1'b1) begin
          n_fail++;
          $display("FAIL ovr_set: got %b expected 1", overrun_o);
        end
      end
      if (cyc == 27) begin
        n_checks++;
        if ({sample_strobe_o, sym_valid_o, sym_i_o, sym_q_o} !== 8'b1_1_001_101) begin
          n_fail++;
          $display("FAIL ovr_latest_sym: got %b expected 1_1_001_101", {sample_strobe_o, sym_valid_o, sym_i_o, sym_q_o});
        end
      end
      if (cyc == 45) begin
        n_checks++;
        if ({sym_valid_o, sym_i_o, sym_q_o} !== 7'b1_001_001) begin
          n_fail++;
          $display("FAIL ovr_third_apply: got %b expected 1_001_001", {sym_valid_o, sym_i_o, sym_q_o});
        end
      end
    end
    n_checks++;
    if (overrun_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun_o);
    end
    rst_o = 1'b1;
    step();
    n_checks++;
    if ({overrun_o, busy_o, sym_i_o, sym_q_o, phase_o} !== 17'd0) begin
      n_fail++;
      $display("FAIL ovr_rst_clear: got %h expected 0", {overrun_o, busy_o, sym_i_o, sym_q_o, phase_o});
    end
  endtask

  task automatic test_first_symbol();
    logic [3:0] s;
    s = 4'b1011;
    release_main();
    last_exp = {3'b011, 3'b001};
    sb_q.push_back(last_exp);
    for (int n = 0; n < 200; n++) begin
      in_m = s[3 - n / 50];
      step();
      if (cyc == 176 || cyc == 177) begin
        n_checks++;
        if ({sym_valid_m, initialize_m} !== ((cyc == 177) ? 2'b10 : 2'b00)) begin
          n_fail++;
          $display("FAIL first_valid_c%0d: got sv/init=%b expected %b", cyc, {sym_valid_m, initialize_m}, (cyc == 177) ? 2'b10 : 2'b00);
        end
      end
      if (cyc == 177) begin
        n_checks++;
        if ({sym_i_m, sym_q_m} !== 6'b011_001) begin
          n_fail++;
          $display("FAIL first_levels: got %b expected 011_001", {sym_i_m, sym_q_m});
        end
      end
      if (cyc == 178) begin
        n_checks++;
        if ({initialize_m, iter_m} !== 5'b1_0000) begin
          n_fail++;
          $display("FAIL first_init: got %b expected 1_0000", {initialize_m, iter_m});
        end
      end
      if (cyc >= 179 && cyc <= 190) begin
        n_checks++;
        if ({initialize_m, sample_strobe_m, iter_m} !== {2'b00, 4'(cyc - 179)}) begin
          n_fail++;
          $display("FAIL iter_seq: got %b expected %b", {initialize_m, sample_strobe_m, iter_m}, {2'b00, 4'(cyc - 179)});
        end
      end
      if (cyc == 191) begin
        n_checks++;
        if ({sample_strobe_m, phase_m} !== 9'b1_00000000) begin
          n_fail++;
          $display("FAIL first_strobe: got %b expected 1_00000000", {sample_strobe_m, phase_m});
        end
      end
    end
  endtask

  task automatic test_all_symbols();
    for (int s = 0; s < 16; s++) begin
      drive_symbol(4'(s));
      n_checks++;
      if ({sym_i_m, sym_q_m} !== {lvl(2'(s >> 2)), lvl(2'(s))}) begin
        n_fail++;
        $display("FAIL sym_%0d: got %b expected %b", s, {sym_i_m, sym_q_m}, {lvl(2'(s >> 2)), lvl(2'(s))});
      end
      if (s == 6) begin
        n_checks++;
        if ({sym_i_m, sym_q_m} !== 6'b111_011) begin
          n_fail++;
          $display("FAIL sym_0110: got %b expected 111_011", {sym_i_m, sym_q_m});
        end
      end
    end
  endtask

  task automatic test_phase_wrap();
    int g;
    g = 0;
    while (strb_cnt < 260 && g < 10) begin
      drive_symbol(4'($urandom_range(0, 15)));
      g++;
    end
    n_checks++;
    if (strb_cnt < 260 || !wrap_seen) begin
      n_fail++;
      $display("FAIL phase_wrap: got strobes=%0d wrap_seen=%0d expected >=260 and 1", strb_cnt, wrap_seen);
    end
  endtask

  task automatic test_en_drop();
    int  n0;
    bit  found;
    found = 1'b0;
    in_m  = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      if (iter_m == 4'd5) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL en_drop_wait: got no iter=5 within 30 cycles, expected one");
    end
    en_m = 1'b0;
    n0 = strb_cnt;
    for (int k = 0; k < 40; k++) step();
    n_checks++;
    if (strb_cnt - n0 != 1) begin
      n_fail++;
      $display("FAIL en_drop_strobes: got %0d expected 1", strb_cnt - n0);
    end
    n_checks++;
    if ({busy_m, phase_m} !== {1'b0, 8'(strb_cnt)}) begin
      n_fail++;
      $display("FAIL en_drop_park: got busy/phase=%b expected %b", {busy_m, phase_m}, {1'b0, 8'(strb_cnt)});
    end
    for (int k = 0; k < 30; k++) step();
    n_checks++;
    if ({busy_m, phase_m, sym_i_m, sym_q_m} !== {1'b0, 8'(strb_cnt), last_exp}) begin
      n_fail++;
      $display("FAIL en_drop_hold: got %b expected %b", {busy_m, phase_m, sym_i_m, sym_q_m}, {1'b0, 8'(strb_cnt), last_exp});
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_iter();
    logic [3:0] s;
    s = 4'b1011;
    release_main();
    sb_q.push_back({3'b011, 3'b001});
    while (cyc < 183) begin
      in_m = s[3 - (cyc + 1) / 50];
      step();
    end
    n_checks++;
    if ({busy_m, iter_m} !== 5'b1_0100) begin
      n_fail++;
      $display("FAIL mid_iter_pre: got busy/iter=%b expected 1_0100", {busy_m, iter_m});
    end
    rst_m = 1'b1;
    step();
    n_checks++;
    if ({sym_i_m, sym_q_m, sym_valid_m, phase_m, initialize_m, iter_m, sample_strobe_m, busy_m, overrun_m} !== 23'd0) begin
      n_fail++;
      $display("FAIL mid_iter_rst: got %h expected 0", {sym_i_m, sym_q_m, sym_valid_m, phase_m, initialize_m, iter_m, sample_strobe_m, busy_m, overrun_m});
    end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_overrun();
    test_first_symbol();
    test_all_symbols();
    test_phase_wrap();
    test_en_drop();
    test_reset_mid_iter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout at %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
